// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller port bundle: ID-stage instruction description in, stall/flush/forward controls out.
// master = pipeline side driving the ID fields, slave = hazard controller.
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int MC_W   = 6,
    parameter int FSW    = 2
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [REG_AW-1:0] id_rd;
    logic              id_rf_we;
    logic              id_is_load;
    logic [MC_W-1:0]   id_mc_len;
    logic              ex_redirect;
    logic [FSW-1:0]    fwd_sel1;
    logic [FSW-1:0]    fwd_sel2;
    logic              stall_if;
    logic              stall_id;
    logic              flush_id;
    logic              mc_busy;
    logic [31:0]       perf_stall;
    logic [31:0]       perf_flush;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
               id_rf_we, id_is_load, id_mc_len, ex_redirect,
        input  fwd_sel1, fwd_sel2, stall_if, stall_id, flush_id, mc_busy,
               perf_stall, perf_flush
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
               id_rf_we, id_is_load, id_mc_len, ex_redirect,
        output fwd_sel1, fwd_sel2, stall_if, stall_id, flush_id, mc_busy,
               perf_stall, perf_flush
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller: EX..WB destination scoreboard, load-use and multi-cycle stalls, redirect flush.
// Optional stall/redirect performance counters are built when HAZ_PERF_EN is defined.
module pipe_hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int MC_W     = 6
) (
    input logic               clk,
    input logic               rst_n,
    pipe_hazard_ctrl_if.slave hz
);
    localparam int NSTG = LOAD_LAT + 2;
    localparam int FSW  = $clog2(NSTG + 1);

    typedef struct packed {
        logic              vld;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              ld;
    } entry_t;

    entry_t [NSTG-1:0] sb;
    logic [MC_W-1:0]   mc_cnt;

    logic [FSW-1:0] sel1, sel2;
    logic           lu1, lu2;
    logic           mc_busy, redir, load_use, hold, stall, accept;
    entry_t         id_entry;

    // Scan oldest to youngest so the youngest matching producer wins; returns {load_use, sel}.
    function automatic logic [FSW:0] lookup(input entry_t [NSTG-1:0] e,
                                            input logic [REG_AW-1:0] rs,
                                            input logic used);
        logic [FSW-1:0] sel;
        logic           lu;
        sel = '0;
        lu  = 1'b0;
        for (int k = NSTG - 1; k >= 0; k--) begin
            if (used && (rs != '0) && e[k].vld && e[k].we && (e[k].rd == rs)) begin
                sel = FSW'(k + 1);
                lu  = e[k].ld && (k < LOAD_LAT);
            end
        end
        return {lu, sel};
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign {lu1, sel1} = lookup(sb, hz.id_rs1, hz.id_rs1_used);
    assign {lu2, sel2} = lookup(sb, hz.id_rs2, hz.id_rs2_used);

    assign mc_busy  = (mc_cnt != '0);
    // A redirect cannot be resolved while EX is occupied by a multi-cycle op.
    assign redir    = hz.ex_redirect && !mc_busy;
    assign load_use = lu1 || lu2;
    assign hold     = load_use || mc_busy;
    assign stall    = hold && !redir;
    assign accept   = hz.id_valid && !stall && !redir;

    assign id_entry = '{vld: 1'b1, rd: hz.id_rd, we: hz.id_rf_we, ld: hz.id_is_load};

    assign hz.fwd_sel1 = hold ? '0 : sel1;
    assign hz.fwd_sel2 = hold ? '0 : sel2;
    assign hz.stall_if = stall;
    assign hz.stall_id = stall;
    assign hz.flush_id = redir;
    assign hz.mc_busy  = mc_busy;

    // Scoreboard advance: EX freezes under a multi-cycle op and MEM receives bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb     <= '0;
            mc_cnt <= '0;
        end else if (mc_busy) begin
            sb[1]  <= '0;
            for (int k = 2; k < NSTG; k++) sb[k] <= sb[k-1];
            mc_cnt <= mc_cnt - MC_W'(1);
        end else begin
            sb[0] <= accept ? id_entry : '0;
            for (int k = 1; k < NSTG; k++) sb[k] <= sb[k-1];
            if (accept) mc_cnt <= hz.id_mc_len;
        end
    end

`ifdef HAZ_PERF_EN
    logic [31:0] perf_stall_q, perf_flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (stall) perf_stall_q <= sat_inc(perf_stall_q);
            if (redir) perf_flush_q <= sat_inc(perf_flush_q);
        end
    end

    assign hz.perf_stall = perf_stall_q;
    assign hz.perf_flush = perf_flush_q;
`else
    assign hz.perf_stall = '0;
    assign hz.perf_flush = '0;
`endif
endmodule
